bf_block_packer: RTL and testbench

//   Consumes the 32-bit word stream leaving the PIPO data register and packs

---
 rtl/bf_block_packer_pkg.sv | 27 ++
 rtl/bf_block_packer_if.sv | 31 +++
 rtl/bf_block_packer_fifo.sv | 85 ++++++++
 rtl/bf_block_packer.sv | 107 ++++++++++
 tb/tb_bf_block_packer.sv | 263 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bf_block_packer_pkg.sv
`default_nettype none
// ============================================================================
// Module : bf_pkg
// Brief  : Shared types for the Blowfish block packer: half-block word,
//          64-bit block split into xL/xR, and the packer pairing phase.
// Rev    : 1.0  initial release
// ============================================================================
package bf_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] bf_word_t;

  // xl occupies the upper half so {xl, xr} reads in arrival order
  typedef struct packed {
    bf_word_t xl;
    bf_word_t xr;
  } bf_block_t;

  // PH_XL: next word becomes xL; PH_XR: xL held, next word completes the block
  typedef enum logic {
    PH_XL = 1'b0,
    PH_XR = 1'b1
  } bf_phase_t;

endpackage
`default_nettype wire

// File: rtl/bf_block_packer_if.sv
`default_nettype none
// ============================================================================
// Module : bf_block_packer_if
// Brief  : Word-in / block-out stream bundle of the block packer.
//          master = word source and round stage, slave = packer.
// Rev    : 1.0  initial release
// ============================================================================
interface bf_block_packer_if #(
  parameter int WORD_W = bf_pkg::WORD_W
) ();

  logic [WORD_W-1:0] in_word;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] out_xl;
  logic [WORD_W-1:0] out_xr;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output in_word, in_valid, out_ready,
    input  in_ready, out_xl, out_xr, out_valid
  );

  modport slave (
    input  in_word, in_valid, out_ready,
    output in_ready, out_xl, out_xr, out_valid
  );

endinterface
`default_nettype wire

// File: rtl/bf_block_packer_fifo.sv
`default_nettype none
// ============================================================================
// Module : bf_block_fifo
// Brief  : DEPTH-entry queue of bf_block_t. Registered, no bypass. The head
//          output falls back to the last popped block while empty so the
//          round stage never sees stale queue contents.
// Rev    : 1.0  initial release
// ============================================================================
module bf_block_fifo
  import bf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  wire logic                   clk,
  input  wire logic                   rst,
  input  wire logic                   clear,
  input  wire logic                   push,
  input  wire bf_block_t              push_blk,
  input  wire logic                   pop,
  output bf_block_t                   head_blk,
  output logic [$clog2(DEPTH):0]      count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int QCW   = PTR_W + 1;

  bf_block_t        mem_q [DEPTH];
  bf_block_t        mem_d [DEPTH];
  bf_block_t        last_q, last_d;
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [QCW-1:0]   cnt_q, cnt_d;

  // Next-state: clear flushes pointers; otherwise apply push/pop independently
  always_comb begin
    mem_d  = mem_q;
    last_d = last_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (clear) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_blk;
        wr_d        = wr_q + PTR_W'(1);
      end
      if (pop) begin
        last_d = mem_q[rd_q];
        rd_d   = rd_q + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + QCW'(1);
        2'b01:   cnt_d = cnt_q - QCW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Queue storage and pointers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      last_q <= '0;
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
    end else begin
      mem_q  <= mem_d;
      last_q <= last_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_blk = (cnt_q != '0) ? mem_q[rd_q] : last_q;
  assign count    = cnt_q;

endmodule
`default_nettype wire

// File: rtl/bf_block_packer.sv
`default_nettype none
// ============================================================================
// Module : bf_block_packer
// Brief  : Pairs consecutive 32-bit PIPO words into Blowfish blocks (xL first,
//          xR second), buffers them in a small queue for the round stage and
//          counts delivered blocks.
// Rev    : 1.0  initial release
// ============================================================================
module bf_block_packer
  import bf_pkg::*;
#(
  parameter int WORD_W = bf_pkg::WORD_W,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         clear,
  bf_block_packer_if.slave  bus,
  output logic              phase,
  output logic [CNT_W-1:0]  blk_count
);

  localparam int QCW = $clog2(DEPTH) + 1;

  bf_phase_t         phase_q, phase_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0]  blk_count_q, blk_count_d;

  logic              in_fire;
  logic              out_fire;
  logic              q_push;
  logic              q_pop;
  logic              q_full;
  logic [QCW-1:0]    q_count;
  bf_block_t         q_push_blk;
  bf_block_t         q_head;

  // Ready/valid: a full queue still takes the xR word when the head leaves
  // in the same cycle, keeping one block per two words under backpressure
  always_comb begin
    q_full        = (q_count == QCW'(DEPTH));
    bus.out_valid = (q_count != '0);
    bus.in_ready  = (phase_q == PH_XL) | ~q_full | (bus.out_valid & bus.out_ready);
    in_fire       = bus.in_valid & bus.in_ready;
    out_fire      = bus.out_valid & bus.out_ready;
    q_push        = in_fire & (phase_q == PH_XR) & ~clear;
    q_pop         = out_fire & ~clear;
    q_push_blk    = '{xl: hold_q, xr: bus.in_word};
    bus.out_xl    = q_head.xl;
    bus.out_xr    = q_head.xr;
  end

  // Pairing phase, xL hold register and delivered-block counter
  always_comb begin
    phase_d     = phase_q;
    hold_d      = hold_q;
    blk_count_d = blk_count_q;
    if (clear) begin
      phase_d = PH_XL;
      hold_d  = '0;
    end else begin
      if (in_fire) begin
        if (phase_q == PH_XL) begin
          hold_d  = bus.in_word;
          phase_d = PH_XR;
        end else begin
          phase_d = PH_XL;
        end
      end
      if (q_pop) begin
        blk_count_d = blk_count_q + CNT_W'(1);
      end
    end
  end

  // Packer state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= PH_XL;
      hold_q      <= '0;
      blk_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      hold_q      <= hold_d;
      blk_count_q <= blk_count_d;
    end
  end

  bf_block_fifo #(
    .DEPTH    (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .push     (q_push),
    .push_blk (q_push_blk),
    .pop      (q_pop),
    .head_blk (q_head),
    .count    (q_count)
  );

  assign phase     = phase_q;
  assign blk_count = blk_count_q;

endmodule
`default_nettype wire

// File: tb/tb_bf_block_packer.sv
`default_nettype none
// ============================================================================
// Module : tb_bf_block_packer
// Brief  : Scoreboard bench for bf_block_packer. Accepted word pairs push the
//          expected block into a queue; a monitor pops and compares on every
//          output handshake. Directed checks cover reset, backpressure,
//          same-cycle push/pop, clear, counter wrap and async reset.
// Rev    : 1.0  initial release
// ============================================================================
module tb_bf_block_packer;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        phase;
  logic [15:0] blk_count;

  bf_block_packer_if #(.WORD_W(32)) bus ();

  bf_block_packer #(
    .WORD_W    (32),
    .DEPTH     (2),
    .CNT_W     (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .bus       (bus),
    .phase     (phase),
    .blk_count (blk_count)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [63:0] exp_q[$];
  logic        m_phase = 1'b0;
  logic [31:0] m_hold  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Bench-side pairing model: second word of a pair queues the expected block
  task automatic accept(input logic [31:0] w);
    if (!m_phase) begin
      m_hold  = w;
      m_phase = 1'b1;
    end else begin
      exp_q.push_back({m_hold, w});
      m_phase = 1'b0;
    end
  endtask

  // Present one word and hold it until the packer takes it (bounded wait)
  task automatic send_word(input logic [31:0] w);
    bit ok;
    ok = 1'b0;
    bus.in_word  = w;
    bus.in_valid = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept_in_time", 64'(ok), 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    if (ok) accept(w);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output handshake must match the oldest expected block
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_block: got %h%h expected none", bus.out_xl, bus.out_xr);
      end else begin
        chk("block", {bus.out_xl, bus.out_xr}, exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    clear         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_word   = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_phase",     64'(phase),         64'd0);
    chk("rst_out_xlxr",  {bus.out_xl, bus.out_xr}, 64'd0);
    chk("rst_blk_count", 64'(blk_count),     64'd0);

    // 1: single block, round stage always ready
    tick();
    bus.out_ready = 1'b1;
    send_word(32'h6608dc4d);
    chk("t1_phase_after_xl", 64'(phase), 64'd1);
    send_word(32'h12345678);
    @(negedge clk);
    chk("t1_out_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_phase",     64'(phase),         64'd0);
    tick();
    @(negedge clk);
    chk("t1_out_valid_drop", 64'(bus.out_valid), 64'd0);
    chk("t1_blk_count",      64'(blk_count),     64'd1);
    chk("t1_hold_last",      {bus.out_xl, bus.out_xr}, 64'h6608dc4d_12345678);

    // 2: backpressure, queue fills after 4 words, word 5 held in phase 1
    tick();
    bus.out_ready = 1'b0;
    send_word(32'hA1A1A1A1);
    send_word(32'hA2A2A2A2);
    send_word(32'hA3A3A3A3);
    send_word(32'hA4A4A4A4);
    send_word(32'hA5A5A5A5);
    @(negedge clk);
    chk("t2_in_ready_full", 64'(bus.in_ready),  64'd0);
    chk("t2_phase",         64'(phase),         64'd1);
    chk("t2_out_valid",     64'(bus.out_valid), 64'd1);
    chk("t2_head",          {bus.out_xl, bus.out_xr}, 64'hA1A1A1A1_A2A2A2A2);
    bus.in_word  = 32'hA6A6A6A6;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      @(negedge clk);
      chk("t2_stall_in_ready", 64'(bus.in_ready), 64'd0);
      chk("t2_stall_head",     {bus.out_xl, bus.out_xr}, 64'hA1A1A1A1_A2A2A2A2);
    end

    // 3: full queue, push and pop in the same cycle
    tick();
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("t3_in_ready_pass", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    accept(32'hA6A6A6A6);
    @(negedge clk);
    chk("t3_out_valid",     64'(bus.out_valid), 64'd1);
    chk("t3_still_full",    64'(bus.in_ready),  64'd1);
    chk("t3_head",          {bus.out_xl, bus.out_xr}, 64'hA3A3A3A3_A4A4A4A4);
    chk("t3_phase",         64'(phase),         64'd0);
    chk("t3_blk_count",     64'(blk_count),     64'd2);
    tick();
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t3_drained_valid", 64'(bus.out_valid), 64'd0);
    chk("t3_drained_count", 64'(blk_count),     64'd4);
    chk("t3_scoreboard",    64'(exp_q.size()),  64'd0);

    // 4: clear drops the held xL, the queued block and a same-cycle word
    tick();
    send_word(32'h01010101);
    send_word(32'h02020202);
    send_word(32'hdeadbeef);
    @(negedge clk);
    chk("t4_phase_before", 64'(phase), 64'd1);
    tick();
    clear        = 1'b1;
    bus.in_word  = 32'hCCCCCCCC;
    bus.in_valid = 1'b1;
    tick();
    clear        = 1'b0;
    bus.in_valid = 1'b0;
    m_phase      = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("t4_phase_after",  64'(phase),         64'd0);
    chk("t4_queue_empty",  64'(bus.out_valid), 64'd0);
    chk("t4_count_kept",   64'(blk_count),     64'd4);
    tick();
    bus.out_ready = 1'b1;
    send_word(32'hAAAA0000);
    send_word(32'hBBBB1111);
    @(negedge clk);
    chk("t4_xl", 64'(bus.out_xl), 64'hAAAA0000);
    tick();
    @(negedge clk);
    chk("t4_blk_count", 64'(blk_count), 64'd5);

    // 5: counter wrap from 0xFFFF
    tick();
    bus.out_ready = 1'b0;
    force dut.blk_count_q = 16'hFFFF;
    tick();
    release dut.blk_count_q;
    send_word(32'h0F0F0F0F);
    send_word(32'hF0F0F0F0);
    @(negedge clk);
    chk("t5_pre_wrap", 64'(blk_count), 64'hFFFF);
    tick();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    @(negedge clk);
    chk("t5_wrap", 64'(blk_count), 64'h0000);

    // 6: async reset mid-cycle with a full queue and xL held
    tick();
    send_word(32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    send_word(32'h44444444);
    send_word(32'h55555555);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t6_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t6_phase",     64'(phase),         64'd0);
    chk("t6_out_xlxr",  {bus.out_xl, bus.out_xr}, 64'd0);
    chk("t6_blk_count", 64'(blk_count),     64'd0);
    m_phase = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send_word(32'h9ABCDEF0);
    send_word(32'h13579BDF);
    tick();
    @(negedge clk);
    chk("t6_post_count", 64'(blk_count),    64'd1);
    chk("t6_scoreboard", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
